link_arbiter: RTL and testbench
===============================

LINK_ARBITER -- requirements
Module: link_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4, number of requesting input links (2..16).
REQ-002 Parameter FLIT_SIZE, default 32, flit data width in bits.
REQ-003 Parameter WDOG_CYCLES, default 1024, stall cycles before the hang flag is raised (only used with the watchdog macro).
REQ-004 Port clk_i  input  1  single clock; all state on its rising edge.
REQ-005 Port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 Port tx_i  input  N_PORTS  per-requester flit valid.
REQ-007 Port eop_i  input  N_PORTS  per-requester end-of-packet marker.
REQ-008 Port data_i  input  N_PORTS x FLIT_SIZE  per-requester flit data.
REQ-009 Port cr_tx_o  output  N_PORTS  per-requester credit back to the requester.
REQ-010 Port tx_o  output  1  shared link flit valid.
REQ-011 Port eop_o  output  1  shared link end-of-packet marker.
REQ-012 Port data_o  output  FLIT_SIZE  shared link flit data.
REQ-013 Port cr_rx_i  input  1  credit from the shared link.
REQ-014 Port grant_o  output  $clog2(N_PORTS)  index of the current owner; valid only while busy_o=1.
REQ-015 Port busy_o  output  1  high while a packet owns the link.

Function
REQ-016 A flit transfer on port p SHALL occur when tx_i[p] and cr_tx_o[p] are both high at a rising edge.
REQ-017 The FSM SHALL have states IDLE and SEND.
REQ-018 In IDLE: tx_o=0, eop_o=0, data_o=0, cr_tx_o=0, busy_o=0.
REQ-019 In IDLE with any tx_i high, the block SHALL latch the winner and enter SEND on the next edge (one-cycle grant latency).
REQ-020 Winner selection SHALL be round-robin: first requester scanning upward from (last_owner+1) mod N_PORTS.
REQ-021 In SEND with owner g: tx_o=tx_i[g], eop_o=eop_i[g], data_o=data_i[g], cr_tx_o[g]=cr_rx_i, and all other cr_tx_o bits SHALL be 0 (combinational pass-through, zero added latency).
REQ-022 In SEND the owner SHALL be held until a transfer with eop_i[g]=1; on that edge the FSM SHALL enter IDLE and last_owner SHALL become g.
REQ-023 Requests arriving while SEND SHALL wait; one IDLE bubble cycle SHALL separate consecutive packets, including when the same requester is the only one pending.
REQ-024 Single-flit packets (eop on the first flit) SHALL be supported.
REQ-025 cr_rx_i low in SEND SHALL stall the owner indefinitely without losing the grant.

Reset
REQ-026 On rst_ni low, asynchronously: state=IDLE, last_owner=N_PORTS-1 (port 0 has first priority), grant_o=0, all outputs at IDLE values.
REQ-027 Reset mid-packet SHALL drop ownership; the interrupted packet is not resumed.

Configuration
REQ-028 Macro LINK_ARBITER_WDOG_EN SHALL compile in a watchdog and an extra output port hang_o (1 bit).
REQ-029 With the macro: a counter SHALL increment each SEND cycle with tx_o=1 and cr_rx_i=0, clear on any transfer or in IDLE, and saturate at WDOG_CYCLES.
REQ-030 With the macro: hang_o SHALL be high while the counter equals WDOG_CYCLES; ownership is unaffected.
REQ-031 Without the macro: no counter and no hang_o port.

Structure
REQ-032 Package link_arbiter_pkg SHALL hold the FSM state enum.
REQ-033 Sub-module rr_arbiter SHALL implement the combinational rotating-priority pick (inputs: request vector and last_owner; outputs: winner index and any-request flag).

Verification
REQ-034 Reset, then tx_i=4'b0101 held -> grant_o=0 one cycle later; after its eop, grant_o=2; after that eop, grant_o=0.
REQ-035 Port 1 sends a 5-flit packet with cr_rx_i low for 3 cycles mid-packet -> 5 flits appear on data_o in order, busy_o stays high, and cr_tx_o[0,2,3] stay 0 throughout.
REQ-036 All four ports request continuously with 1-flit packets -> grant order is 0,1,2,3,0, with one IDLE cycle between grants.
REQ-037 rst_ni is pulsed low during the 3rd flit of port 3's packet -> tx_o=0 immediately, and the next grant goes to port 0 if it is requesting.
REQ-038 With LINK_ARBITER_WDOG_EN, WDOG_CYCLES=8, and cr_rx_i low with tx_o high for 8 cycles -> hang_o rises on the 8th edge and clears on the edge of the next transfer.

Source files
------------

// File: rtl/link_arbiter_pkg.sv
// Shared types for the link arbiter: FSM state encoding and the index wrap helper
// used by the rotating-priority pick.
package link_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } link_state_e;

    function automatic int wrap_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/link_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester found scanning upward from
// the port after last_owner_i, wrapping at N_PORTS.
module rr_arbiter
    import link_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        winner_o  = '0;
        found     = 1'b0;
        idx       = '0;
        any_req_o = |req_i;
        // Offset 1 is the highest priority, offset N_PORTS (the last owner itself) the lowest.
        for (int i = 1; i <= N_PORTS; i++) begin
            idx = IDX_W'(wrap_index(32'(last_owner_i), i, N_PORTS));
            if (!found && req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/link_arbiter.sv
// Packet-level arbiter granting one of N_PORTS requesters the shared link.
// Optional watchdog with hang_o output is compiled in by LINK_ARBITER_WDOG_EN.
module link_arbiter
    import link_arbiter_pkg::*;
#(
    parameter int N_PORTS     = 4,
    parameter int FLIT_SIZE   = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_PORTS-1:0]            tx_i,
    input  logic [N_PORTS-1:0]            eop_i,
    input  logic [N_PORTS*FLIT_SIZE-1:0]  data_i,
    output logic [N_PORTS-1:0]            cr_tx_o,
    output logic                          tx_o,
    output logic                          eop_o,
    output logic [FLIT_SIZE-1:0]          data_o,
    input  logic                          cr_rx_i,
    output logic [$clog2(N_PORTS)-1:0]    grant_o,
`ifdef LINK_ARBITER_WDOG_EN
    output logic                          hang_o,
`endif
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(N_PORTS);

    if (N_PORTS < 2 || N_PORTS > 16 || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("link_arbiter: unsupported parameter set");
    end

    link_state_e          state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;

    logic [IDX_W-1:0]     winner;
    logic                 any_req;
    logic                 owner_tx;
    logic                 owner_eop;
    logic [FLIT_SIZE-1:0] owner_data;
    logic                 xfer;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i        (tx_i),
        .last_owner_i (last_owner_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    assign owner_tx   = tx_i[owner_q];
    assign owner_eop  = eop_i[owner_q];
    assign owner_data = data_i[int'(owner_q) * FLIT_SIZE +: FLIT_SIZE];
    assign xfer       = (state_q == ST_SEND) && owner_tx && cr_rx_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_PORTS - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // The edge carrying the last flit releases the link; the IDLE bubble follows.
                if (xfer && owner_eop) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_o    = 1'b0;
        eop_o   = 1'b0;
        data_o  = '0;
        cr_tx_o = '0;
        busy_o  = 1'b0;
        if (state_q == ST_SEND) begin
            tx_o             = owner_tx;
            eop_o            = owner_eop;
            data_o           = owner_data;
            cr_tx_o[owner_q] = cr_rx_i;
            busy_o           = 1'b1;
        end
    end

    assign grant_o = owner_q;

`ifdef LINK_ARBITER_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // Counts only cycles where the owner offers a flit but the link withholds credit.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q != ST_SEND || xfer) begin
            wdog_d = '0;
        end else if (owner_tx && !cr_rx_i && wdog_q != WDOG_W'(WDOG_CYCLES)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    assign hang_o = (wdog_q == WDOG_W'(WDOG_CYCLES));
`endif

endmodule

// File: tb/tb_link_arbiter.sv
// Self-checking bench for link_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a packet-level reference model.
module tb_link_arbiter;

    localparam int NP = 4;
    localparam int FW = 32;
    localparam int WD = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NP-1:0]     tx_i, eop_i, cr_tx_o;
    logic [NP*FW-1:0]  data_i;
    logic              tx_o, eop_o, cr_rx_i, busy_o;
    logic [FW-1:0]     data_o;
    logic [1:0]        grant_o;
`ifdef LINK_ARBITER_WDOG_EN
    logic              hang_o;
`endif

    link_arbiter #(
        .N_PORTS     (NP),
        .FLIT_SIZE   (FW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tx_i    (tx_i),
        .eop_i   (eop_i),
        .data_i  (data_i),
        .cr_tx_o (cr_tx_o),
        .tx_o    (tx_o),
        .eop_o   (eop_o),
        .data_o  (data_o),
        .cr_rx_i (cr_rx_i),
        .grant_o (grant_o),
`ifdef LINK_ARBITER_WDOG_EN
        .hang_o  (hang_o),
`endif
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int vectorCount = 0;
    int missCount   = 0;

    // Reference model: who owns the link, who owned it last, and the stall count.
    bit          busyM;
    int          ownerM;
    int          lastM;
    int          wdogM;
    int          xferPort;
    logic [FW-1:0] xferData;
    bit          xferEop;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic int rrPick(input logic [NP-1:0] req, input int last);
        for (int off = 1; off <= NP; off++) begin
            if (req[(last + off) % NP]) return (last + off) % NP;
        end
        return -1;
    endfunction

    task automatic checkModel();
        logic [NP-1:0] crExp;
        crExp = '0;
        if (busyM) crExp[ownerM] = cr_rx_i;
        checkOutput("busy_o", busy_o, busyM);
        checkOutput("tx_o", tx_o, busyM ? tx_i[ownerM] : 1'b0);
        checkOutput("eop_o", eop_o, busyM ? eop_i[ownerM] : 1'b0);
        checkOutput("data_o", data_o, busyM ? data_i[ownerM*FW +: FW] : '0);
        checkOutput("cr_tx_o", cr_tx_o, crExp);
        if (busyM) checkOutput("grant_o", grant_o, ownerM);
`ifdef LINK_ARBITER_WDOG_EN
        checkOutput("hang_o", hang_o, wdogM == WD);
`endif
    endtask

    task automatic advanceModel();
        int p;
        xferPort = -1;
        if (!busyM) begin
            wdogM = 0;
            p = rrPick(tx_i, lastM);
            if (p >= 0) begin
                busyM  = 1'b1;
                ownerM = p;
            end
        end else if (tx_i[ownerM] && cr_rx_i) begin
            xferPort = ownerM;
            xferData = data_i[ownerM*FW +: FW];
            xferEop  = eop_i[ownerM];
            wdogM    = 0;
            if (eop_i[ownerM]) begin
                busyM = 1'b0;
                lastM = ownerM;
            end
        end else if (tx_i[ownerM] && !cr_rx_i && wdogM < WD) begin
            wdogM++;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic applyStimulus(input logic [NP-1:0] tx, input logic [NP-1:0] eop,
                                 input logic [NP*FW-1:0] data, input logic cr);
        tx_i    = tx;
        eop_i   = eop;
        data_i  = data;
        cr_rx_i = cr;
        #3;
        checkModel();
        @(posedge clk_i);
        advanceModel();
        #1;
    endtask

    // Asynchronous reset pulse; input values are left as the caller drove them.
    task automatic doReset();
        rst_ni = 1'b0;
        #1;
        busyM    = 1'b0;
        ownerM   = 0;
        lastM    = NP - 1;
        wdogM    = 0;
        xferPort = -1;
        checkOutput("rst tx_o", tx_o, 1'b0);
        checkOutput("rst busy_o", busy_o, 1'b0);
        checkOutput("rst grant_o", grant_o, 0);
        checkOutput("rst cr_tx_o", cr_tx_o, 0);
        checkOutput("rst data_o", data_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    function automatic logic [NP*FW-1:0] randData();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int grants[$];
        logic [FW-1:0] flits[$];
        int k;
        int stalls;
        bit done;
        logic [NP-1:0] txr, eopr;

        rst_ni  = 1'b1;
        tx_i    = '0;
        eop_i   = '0;
        data_i  = '0;
        cr_rx_i = 1'b0;
        #1;
        doReset();

        // Round-robin between ports 0 and 2 holding requests.
        applyStimulus(4'b0101, 4'b0000, randData(), 1'b1);
        checkOutput("alt grant0", grant_o, 0);
        applyStimulus(4'b0101, 4'b0001, randData(), 1'b1);
        applyStimulus(4'b0101, 4'b0000, randData(), 1'b1);
        checkOutput("alt grant2", grant_o, 2);
        applyStimulus(4'b0101, 4'b0100, randData(), 1'b1);
        applyStimulus(4'b0101, 4'b0000, randData(), 1'b1);
        checkOutput("alt grant0b", grant_o, 0);

        // All ports streaming single-flit packets.
        doReset();
        grants.delete();
        for (int s = 0; s < 9; s++) begin
            applyStimulus(4'hF, 4'hF, randData(), 1'b1);
            checkOutput("stream busy", busy_o, (s % 2) == 0);
            if (busy_o) grants.push_back(int'(grant_o));
        end
        checkOutput("stream count", grants.size(), 5);
        for (int s = 0; s < grants.size() && s < 5; s++) begin
            checkOutput("stream order", grants[s], (s == 4) ? 0 : s);
        end

        // Port 1 five-flit packet, credit withheld three cycles on the third flit.
        doReset();
        k = 0; stalls = 0; done = 1'b0;
        flits.delete();
        for (int c = 0; c < 40 && !done; c++) begin
            logic [NP*FW-1:0] d;
            logic cr;
            d = randData();
            d[FW +: FW] = 32'hA000_0000 + k;
            cr = !(busyM && k == 2 && stalls < 3);
            if (!cr) stalls++;
            applyStimulus((c == 0) ? 4'b0010 : 4'b1111, (k == 4) ? 4'b0010 : 4'b0000, d, cr);
            if (xferPort == 1) begin
                flits.push_back(xferData);
                k++;
                if (xferEop) done = 1'b1;
            end
            if (!done && c > 0) begin
                checkOutput("pkt busy", busy_o, 1'b1);
                checkOutput("pkt others cr", cr_tx_o & 4'b1101, 4'b0000);
            end
        end
        checkOutput("pkt done", done, 1'b1);
        checkOutput("pkt flits", flits.size(), 5);
        for (int s = 0; s < flits.size() && s < 5; s++) begin
            checkOutput("pkt order", flits[s], 32'hA000_0000 + s);
        end

        // Reset during the third flit of port 3's packet.
        doReset();
        applyStimulus(4'b1000, 4'b0000, randData(), 1'b1);
        applyStimulus(4'b1000, 4'b0000, randData(), 1'b1);
        applyStimulus(4'b1000, 4'b0000, randData(), 1'b1);
        checkOutput("mid tx before", tx_o, 1'b1);
        doReset();
        applyStimulus(4'b1001, 4'b0000, randData(), 1'b1);
        checkOutput("mid regrant", grant_o, 0);

`ifdef LINK_ARBITER_WDOG_EN
        doReset();
        applyStimulus(4'b0100, 4'b0000, randData(), 1'b1);
        for (int j = 1; j <= WD; j++) begin
            applyStimulus(4'b0100, 4'b0000, randData(), 1'b0);
            checkOutput("wdog hang", hang_o, j == WD);
        end
        applyStimulus(4'b0100, 4'b0000, randData(), 1'b1);
        checkOutput("wdog clear", hang_o, 1'b0);
`endif

        // Randomized traffic, with a long credit drought and a reset mid-run.
        doReset();
        for (int c = 0; c < 1500; c++) begin
            txr  = NP'($urandom_range(0, 15));
            eopr = NP'($urandom() & $urandom());
            if (c == 700) doReset();
            applyStimulus(txr, eopr, randData(),
                          (c >= 300 && c < 315) ? 1'b0 : ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
